reqrsp_mem_bridge: RTL and testbench

REQRSP_MEM_BRIDGE -- requirements
Module: reqrsp_mem_bridge

---
 rtl/reqrsp_pkg.sv | 19 +
 rtl/fifo_v3.sv | 64 ++++++
 rtl/reqrsp_mem_bridge.sv | 102 ++++++++++
 tb/tb_reqrsp_mem_bridge.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reqrsp_pkg.sv
// Shared request/response types: atomic memory operation encoding.
package reqrsp_pkg;

    typedef enum logic [3:0] {
        AMONone = 4'h0,
        AMOSwap = 4'h1,
        AMOAdd  = 4'h2,
        AMOAnd  = 4'h3,
        AMOOr   = 4'h4,
        AMOXor  = 4'h5,
        AMOMax  = 4'h6,
        AMOMaxu = 4'h7,
        AMOMin  = 4'h8,
        AMOMinu = 4'h9,
        AMOLR   = 4'hA,
        AMOSC   = 4'hB
    } amo_op_e;

endpackage

// File: rtl/fifo_v3.sv
// Non-fall-through FIFO: a pushed word is first visible on data_o the cycle after the push.
module fifo_v3 #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  empty_o
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(DEPTH - 1);
    localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  full, do_push, do_pop;

    assign full    = (cnt_q == FullCnt);
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i & ~full;
    assign do_pop  = pop_i & ~empty_o;
    assign data_o  = mem_q[rd_ptr_q];

    // NOTE: every variable assigned in always_comb gets a default first, so no path infers a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + PtrW'(1);
        if (do_pop)  rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + PtrW'(1);
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CntW'(1);
            2'b01:   cnt_d = cnt_q - CntW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // NOTE: storage is deliberately not reset; cnt_q alone says which entries are meaningful.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/reqrsp_mem_bridge.sv
// Credit-limited bridge from a req/rsp port to a fixed-latency memory.
// Define REQRSP_MEM_BRIDGE_AMO_EN to forward atomics; otherwise they issue as plain reads.
module reqrsp_mem_bridge
    import reqrsp_pkg::*;
#(
    parameter  int unsigned AddrWidth  = 32,
    parameter  int unsigned DataWidth  = 64,
    parameter  int unsigned MemLatency = 1,
    parameter  int unsigned RspDepth   = 2,
    localparam int unsigned StrbWidth  = DataWidth / 8,
    localparam int unsigned CntWidth   = $clog2(RspDepth + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [AddrWidth-1:0] req_q_addr_i,
    input  logic                 req_q_write_i,
    input  amo_op_e              req_q_amo_i,
    input  logic [DataWidth-1:0] req_q_data_i,
    input  logic [StrbWidth-1:0] req_q_strb_i,
    input  logic                 req_q_valid_i,
    output logic                 req_q_ready_o,
    output logic [DataWidth-1:0] rsp_p_data_o,
    output logic                 rsp_p_valid_o,
    input  logic                 rsp_p_ready_i,
    output logic [AddrWidth-1:0] mem_q_addr_o,
    output logic                 mem_q_write_o,
    output amo_op_e              mem_q_amo_o,
    output logic [DataWidth-1:0] mem_q_data_o,
    output logic [StrbWidth-1:0] mem_q_strb_o,
    output logic                 mem_q_valid_o,
    input  logic                 mem_q_ready_i,
    input  logic [DataWidth-1:0] mem_p_data_i,
    output logic [CntWidth-1:0]  outstanding_o
);

    localparam logic [CntWidth-1:0] MaxOutstanding = CntWidth'(RspDepth);

    logic [CntWidth-1:0]   outstanding_q, outstanding_d;
    logic [MemLatency-1:0] inflight_q, inflight_d;
    logic                  credit, q_hs, p_hs, fifo_empty;

    // Credit comes only from the registered count: a pop this cycle does not free a slot until next cycle.
    assign credit        = rst_i | (outstanding_q < MaxOutstanding);
    assign mem_q_valid_o = req_q_valid_i & credit;
    assign req_q_ready_o = mem_q_ready_i & credit;
    assign q_hs          = req_q_valid_i & req_q_ready_o;

    assign rsp_p_valid_o = ~rst_i & ~fifo_empty;
    assign p_hs          = rsp_p_valid_o & rsp_p_ready_i;
    assign outstanding_o = rst_i ? '0 : outstanding_q;

    always_comb begin
        mem_q_addr_o = req_q_addr_i;
        mem_q_data_o = req_q_data_i;
        mem_q_strb_o = req_q_strb_i;
`ifdef REQRSP_MEM_BRIDGE_AMO_EN
        mem_q_amo_o   = req_q_amo_i;
        mem_q_write_o = req_q_write_i;
`else
        mem_q_amo_o   = AMONone;
        mem_q_write_o = req_q_write_i & (req_q_amo_i == AMONone);
`endif
    end

    always_comb begin
        inflight_d    = '0;
        inflight_d[0] = q_hs;
        for (int i = 1; i < int'(MemLatency); i++) begin
            inflight_d[i] = inflight_q[i-1];
        end
        case ({q_hs, p_hs})
            2'b10:   outstanding_d = outstanding_q + CntWidth'(1);
            2'b01:   outstanding_d = outstanding_q - CntWidth'(1);
            default: outstanding_d = outstanding_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            inflight_q    <= '0;
            outstanding_q <= '0;
        end else begin
            inflight_q    <= inflight_d;
            outstanding_q <= outstanding_d;
        end
    end

    // The last in-flight stage marks the cycle the memory drives its response.
    fifo_v3 #(
        .DATA_WIDTH (DataWidth),
        .DEPTH      (RspDepth)
    ) i_rsp_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (inflight_q[MemLatency-1]),
        .data_i  (mem_p_data_i),
        .pop_i   (p_hs),
        .data_o  (rsp_p_data_o),
        .empty_o (fifo_empty)
    );

endmodule

// File: tb/tb_reqrsp_mem_bridge.sv
// Directed self-checking bench for reqrsp_mem_bridge with default parameters (L=1, RspDepth=2).
module tb_reqrsp_mem_bridge;
    import reqrsp_pkg::*;

    localparam int AW = 32;
    localparam int DW = 64;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic [AW-1:0] req_q_addr_i;
    logic          req_q_write_i;
    amo_op_e       req_q_amo_i;
    logic [DW-1:0] req_q_data_i;
    logic [7:0]    req_q_strb_i;
    logic          req_q_valid_i;
    logic          req_q_ready_o;
    logic [DW-1:0] rsp_p_data_o;
    logic          rsp_p_valid_o;
    logic          rsp_p_ready_i;
    logic [AW-1:0] mem_q_addr_o;
    logic          mem_q_write_o;
    amo_op_e       mem_q_amo_o;
    logic [DW-1:0] mem_q_data_o;
    logic [7:0]    mem_q_strb_o;
    logic          mem_q_valid_o;
    logic          mem_q_ready_i;
    logic [DW-1:0] mem_p_data_i = '0;
    logic [1:0]    outstanding_o;

    int            n_checks = 0;
    int            n_bad    = 0;
    int            n_rsp    = 0;
    logic [DW-1:0] exp_q[$];

    always #5 clk_i = ~clk_i;

    reqrsp_mem_bridge dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .req_q_addr_i  (req_q_addr_i),
        .req_q_write_i (req_q_write_i),
        .req_q_amo_i   (req_q_amo_i),
        .req_q_data_i  (req_q_data_i),
        .req_q_strb_i  (req_q_strb_i),
        .req_q_valid_i (req_q_valid_i),
        .req_q_ready_o (req_q_ready_o),
        .rsp_p_data_o  (rsp_p_data_o),
        .rsp_p_valid_o (rsp_p_valid_o),
        .rsp_p_ready_i (rsp_p_ready_i),
        .mem_q_addr_o  (mem_q_addr_o),
        .mem_q_write_o (mem_q_write_o),
        .mem_q_amo_o   (mem_q_amo_o),
        .mem_q_data_o  (mem_q_data_o),
        .mem_q_strb_o  (mem_q_strb_o),
        .mem_q_valid_o (mem_q_valid_o),
        .mem_q_ready_i (mem_q_ready_i),
        .mem_p_data_i  (mem_p_data_i),
        .outstanding_o (outstanding_o)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return {~a, a};
    endfunction

    // Memory answers one cycle after each accepted request.
    always @(posedge clk_i) begin
        mem_p_data_i <= (mem_q_valid_o && mem_q_ready_i) ? mem_word(mem_q_addr_o) : '0;
    end

    // Response scoreboard: every upstream handshake must match the oldest accepted request.
    always @(negedge clk_i) begin
        if (!rst_i && rsp_p_valid_o && rsp_p_ready_i) begin
            if (exp_q.size() == 0) check("rsp_unexpected", rsp_p_valid_o, 0);
            else                   check("rsp_data", rsp_p_data_o, exp_q.pop_front());
            n_rsp++;
        end
    end

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic [AW-1:0] addr, input logic wr, input amo_op_e amo,
                         input logic [DW-1:0] data, input logic [7:0] strb);
        req_q_addr_i  = addr;
        req_q_write_i = wr;
        req_q_amo_i   = amo;
        req_q_data_i  = data;
        req_q_strb_i  = strb;
        req_q_valid_i = 1'b1;
    endtask

    task automatic idle();
        req_q_valid_i = 1'b0;
    endtask

    task automatic wait_accept(input logic [AW-1:0] addr);
        for (int k = 0; k < 50; k++) begin
            @(negedge clk_i);
            if (req_q_ready_o) begin
                exp_q.push_back(mem_word(addr));
                cyc();
                return;
            end
            cyc();
        end
        check("accept_timeout", req_q_ready_o, 1);
    endtask

    task automatic send(input logic [AW-1:0] addr);
        drive(addr, 1'b0, AMONone, '0, '0);
        wait_accept(addr);
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 30; k++) begin
            if (exp_q.size() == 0) break;
            cyc();
        end
        check("drain", exp_q.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_rsp;
        int acc;
        rst_i = 1'b1;
        rsp_p_ready_i = 1'b1;
        mem_q_ready_i = 1'b1;
        drive('0, 1'b0, AMONone, '0, '0);
        idle();

        // Reset state, ready follows memory ready.
        cyc(); cyc();
        @(negedge clk_i);
        check("rst_valid", rsp_p_valid_o, 0);
        check("rst_out", outstanding_o, 0);
        check("rst_ready_hi", req_q_ready_o, 1);
        mem_q_ready_i = 1'b0;
        #1;
        check("rst_ready_lo", req_q_ready_o, 0);
        mem_q_ready_i = 1'b1;
        cyc();
        rst_i = 1'b0;
        cyc();

        // Single read: accepted cycle t, visible cycle t+2.
        drive(32'hDEAD_BEEF, 1'b0, AMONone, '0, '0);
        @(negedge clk_i);
        check("rd_mem_addr", mem_q_addr_o, 32'hDEAD_BEEF);
        check("rd_mem_valid", mem_q_valid_o, 1);
        check("rd_req_ready", req_q_ready_o, 1);
        exp_q.push_back(mem_word(32'hDEAD_BEEF));
        cyc();
        idle();
        @(negedge clk_i);
        check("rd_early", rsp_p_valid_o, 0);
        check("rd_out1", outstanding_o, 1);
        cyc();
        @(negedge clk_i);
        check("rd_valid", rsp_p_valid_o, 1);
        check("rd_data", rsp_p_data_o, 64'h2152_4110_DEAD_BEEF);
        cyc();
        @(negedge clk_i);
        check("rd_out0", outstanding_o, 0);
        check("rd_gone", rsp_p_valid_o, 0);
        cyc();

        // Back-to-back reads, all returned in order.
        base_rsp = n_rsp;
        for (int i = 0; i < 8; i++) send(32'h1000_0000 + 32'(i * 8));
        idle();
        wait_drain();
        check("b2b_count", n_rsp - base_rsp, 8);

        // Upstream stalled: credit runs out at two, data held, no same-cycle bypass.
        rsp_p_ready_i = 1'b0;
        send(32'h2000_0000);
        send(32'h2000_0010);
        drive(32'h2000_0020, 1'b0, AMONone, '0, '0);
        @(negedge clk_i);
        check("full_ready", req_q_ready_o, 0);
        check("full_out", outstanding_o, 2);
        check("full_valid", rsp_p_valid_o, 1);
        check("hold_data0", rsp_p_data_o, mem_word(32'h2000_0000));
        cyc(); cyc();
        @(negedge clk_i);
        check("hold_data1", rsp_p_data_o, mem_word(32'h2000_0000));
        check("still_blocked", req_q_ready_o, 0);
        cyc();
        rsp_p_ready_i = 1'b1;
        @(negedge clk_i);
        check("no_bypass", req_q_ready_o, 0);
        cyc();
        wait_accept(32'h2000_0020);
        send(32'h2000_0030);
        idle();
        wait_drain();

        // Memory ready toggling every other cycle.
        base_rsp = n_rsp;
        acc = 0;
        for (int c = 0; c < 40 && acc < 6; c++) begin
            mem_q_ready_i = c[0];
            drive(32'h3000_0000 + 32'(acc * 4), 1'b0, AMONone, '0, '0);
            @(negedge clk_i);
            check("tog_ready", req_q_ready_o, mem_q_ready_i);
            if (req_q_ready_o) begin
                exp_q.push_back(mem_word(32'h3000_0000 + 32'(acc * 4)));
                acc++;
            end
            cyc();
        end
        idle();
        mem_q_ready_i = 1'b1;
        check("tog_accepted", acc, 6);
        wait_drain();
        check("tog_count", n_rsp - base_rsp, 6);

        // Atomic and plain write field forwarding.
        drive(32'h4000_0000, 1'b1, AMOAdd, 64'h0123_4567_89AB_CDEF, 8'hF0);
        #2;
`ifdef REQRSP_MEM_BRIDGE_AMO_EN
        check("amo_op", mem_q_amo_o, AMOAdd);
        check("amo_write", mem_q_write_o, 1);
`else
        check("amo_op", mem_q_amo_o, AMONone);
        check("amo_write", mem_q_write_o, 0);
`endif
        check("amo_data", mem_q_data_o, 64'h0123_4567_89AB_CDEF);
        check("amo_strb", mem_q_strb_o, 8'hF0);
        wait_accept(32'h4000_0000);
        drive(32'h4000_0040, 1'b1, AMONone, 64'hFEDC_BA98_7654_3210, 8'h0F);
        #2;
        check("wr_write", mem_q_write_o, 1);
        check("wr_amo", mem_q_amo_o, AMONone);
        check("wr_strb", mem_q_strb_o, 8'h0F);
        wait_accept(32'h4000_0040);
        idle();
        wait_drain();

        // Reset with two responses buffered.
        rsp_p_ready_i = 1'b0;
        send(32'h5000_0000);
        send(32'h5000_0008);
        idle();
        cyc();
        @(negedge clk_i);
        check("pre_rst_out", outstanding_o, 2);
        check("pre_rst_valid", rsp_p_valid_o, 1);
        cyc();
        rst_i = 1'b1;
        exp_q.delete();
        #2;
        check("rst_mid_out", outstanding_o, 0);
        check("rst_mid_valid", rsp_p_valid_o, 0);
        cyc();
        rst_i = 1'b0;
        #2;
        check("post_rst_valid", rsp_p_valid_o, 0);
        check("post_rst_out", outstanding_o, 0);
        check("post_rst_ready", req_q_ready_o, 1);
        rsp_p_ready_i = 1'b1;
        cyc();

        // Reset while a memory response is in flight: it must be dropped.
        send(32'h6000_0000);
        idle();
        rst_i = 1'b1;
        exp_q.delete();
        cyc();
        rst_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            check("late_rsp_valid", rsp_p_valid_o, 0);
            check("late_rsp_out", outstanding_o, 0);
            cyc();
        end

        // Normal traffic after reset.
        base_rsp = n_rsp;
        send(32'h7000_0000);
        send(32'h7000_0100);
        idle();
        wait_drain();
        check("recover_count", n_rsp - base_rsp, 2);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
